// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-channel mux and its scan pointer.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Select/channel-index width for a given channel count (at least 1 bit).
  function automatic int unsigned sel_width(input int unsigned channels);
    return (channels < 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin channel pointer with a per-channel dwell count for scan mode.
module mux_scan_ptr
  import mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = 8,
  parameter  int unsigned DWELL    = 1,
  localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [SEL_W-1:0] ptr
);

  localparam int unsigned CNT_W = $clog2(DWELL + 1);

  logic [CNT_W-1:0] dcnt;

  // Hold on idle; step dwell count per accepted word and wrap the pointer by compare.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr  <= '0;
      dcnt <= '0;
    end else if (advance) begin
      if (dcnt == CNT_W'(DWELL - 1)) begin
        dcnt <= '0;
        ptr  <= (ptr == SEL_W'(CHANNELS - 1)) ? '0 : ptr + SEL_W'(1);
      end else begin
        dcnt <= dcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_nch_reg.sv
// Registered CHANNELS:1 word mux with valid/ready output and direct or scan selection.
module mux_nch_reg
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 8,
  parameter  int unsigned DWELL    = 1,
  localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic             accept_c;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx_c;
  logic [WIDTH-1:0] word_c;
  logic             in_range_c;
  logic             err_c;

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;
  assign idx_c    = (mode == MODE_SCAN) ? ptr : sel;
  assign err_c    = (mode == MODE_DIRECT) && !in_range_c;

  // Scan pointer only advances on accepted words and restarts whenever direct mode is active.
  mux_scan_ptr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear   (mode == MODE_DIRECT),
    .advance (accept_c && (mode == MODE_SCAN)),
    .ptr     (ptr)
  );

  // Word select by match, so an index past the last channel yields zero and flags out-of-range.
  always_comb begin
    word_c     = '0;
    in_range_c = 1'b0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (idx_c == SEL_W'(k)) begin
        word_c     = din[k*WIDTH +: WIDTH];
        in_range_c = 1'b1;
      end
    end
  end

  // Output register: load on accept, empty when ready without a new word, hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      out_ch    <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_ready) begin
      if (in_valid) begin
        dout      <= word_c;
        out_ch    <= idx_c;
        out_err   <= err_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nch_reg.sv
// Randomized bench for mux_nch_reg: an 8-channel/dwell-2 and a 5-channel/dwell-3 instance.
module tb_mux_nch_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] din_a;
  logic [2:0]  sel_a;
  logic        mode_a, iv_a, ordy_a;
  logic        in_ready_a, out_err_a, out_valid_a;
  logic [7:0]  dout_a;
  logic [2:0]  out_ch_a;

  logic [39:0] din_b;
  logic [2:0]  sel_b;
  logic        mode_b, iv_b, ordy_b;
  logic        in_ready_b, out_err_b, out_valid_b;
  logic [7:0]  dout_b;
  logic [2:0]  out_ch_b;

  mux_nch_reg #(.WIDTH(8), .CHANNELS(8), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .mode(mode_a),
    .in_valid(iv_a), .in_ready(in_ready_a), .dout(dout_a), .out_ch(out_ch_a),
    .out_err(out_err_a), .out_valid(out_valid_a), .out_ready(ordy_a)
  );

  mux_nch_reg #(.WIDTH(8), .CHANNELS(5), .DWELL(3)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode_b),
    .in_valid(iv_b), .in_ready(in_ready_b), .dout(dout_b), .out_ch(out_ch_b),
    .out_err(out_err_b), .out_valid(out_valid_b), .out_ready(ordy_b)
  );

  // Reference state: the presented word plus the number of words accepted since scan began.
  typedef struct {
    bit ov;
    int dout;
    int ch;
    bit err;
    int scnt;
  } mstate_t;

  mstate_t ma, mb;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scan channel is the accept count divided by dwell, modulo the channel count.
  function automatic mstate_t step(mstate_t s, int chans, int dwell, bit r, bit md,
                                   int sel, bit iv, bit ordy, logic [63:0] din);
    mstate_t n;
    bit rdy, acc;
    int idx;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    rdy = !s.ov || ordy;
    acc = iv && rdy;
    idx = md ? (s.scnt / dwell) % chans : sel;
    if (acc) begin
      n.ov   = 1'b1;
      n.ch   = idx;
      n.err  = (idx >= chans);
      n.dout = n.err ? 0 : int'(din[idx*8 +: 8]);
    end else if (rdy) begin
      n.ov = 1'b0;
    end
    if (!md)      n.scnt = 0;
    else if (acc) n.scnt = (s.scnt + 1) % (chans * dwell);
    return n;
  endfunction

  task automatic cycle(input int pv, input int pr, input int pm, input int prst, input bit do_check);
    @(negedge clk);
    rst    = ($urandom_range(99) < prst);
    mode_a = ($urandom_range(99) < pm);
    mode_b = ($urandom_range(99) < pm);
    iv_a   = ($urandom_range(99) < pv);
    iv_b   = ($urandom_range(99) < pv);
    ordy_a = ($urandom_range(99) < pr);
    ordy_b = ($urandom_range(99) < pr);
    sel_a  = 3'($urandom);
    sel_b  = 3'($urandom);
    din_a  = {$urandom, $urandom};
    din_b  = 40'({$urandom, $urandom});
    #1;
    if (do_check) begin
      check("a_in_ready",  32'(in_ready_a),  32'(!ma.ov || ordy_a));
      check("a_out_valid", 32'(out_valid_a), 32'(ma.ov));
      check("a_dout",      32'(dout_a),      32'(ma.dout));
      check("a_out_ch",    32'(out_ch_a),    32'(ma.ch));
      check("a_out_err",   32'(out_err_a),   32'(ma.err));
      check("b_in_ready",  32'(in_ready_b),  32'(!mb.ov || ordy_b));
      check("b_out_valid", 32'(out_valid_b), 32'(mb.ov));
      check("b_dout",      32'(dout_b),      32'(mb.dout));
      check("b_out_ch",    32'(out_ch_b),    32'(mb.ch));
      check("b_out_err",   32'(out_err_b),   32'(mb.err));
    end
    @(posedge clk);
    ma = step(ma, 8, 2, rst, mode_a, int'(sel_a), iv_a, ordy_a, din_a);
    mb = step(mb, 5, 3, rst, mode_b, int'(sel_b), iv_b, ordy_b, 64'(din_b));
  endtask

  task automatic phase(input int n, input int pv, input int pr, input int pm, input int prst);
    for (int i = 0; i < n; i++) cycle(pv, pr, pm, prst, 1'b1);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    cycle(0, 100, 0, 100, 1'b0);
    phase(2,   0,   100, 0,   100);
    phase(40,  100, 100, 0,   0);
    phase(200, 70,  50,  0,   0);
    phase(2,   100, 0,   0,   100);
    phase(60,  100, 100, 100, 0);
    phase(300, 60,  60,  100, 0);
    phase(300, 80,  70,  85,  0);
    phase(300, 75,  60,  60,  4);
    phase(200, 100, 100, 50,  0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
